// File: rtl/ins_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ins_loader_pkg;

  // Stream framing: a big-endian word count header, then big-endian words.
  localparam int HDR_BYTES      = 2;
  localparam int HDR_BITS       = 8 * HDR_BYTES;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // Control outputs held in registers alongside the state register.
  typedef struct packed {
    logic in_ready;
    logic mem_we;
    logic cpu_rst;
    logic done;
    logic err;
  } ctl_t;

  // Output levels that belong to each state. Loaded into the control
  // register on the same edge the state register takes the new state,
  // so the outputs always match the state without any combinational path.
  function automatic ctl_t ctl_for(input state_t s);
    ctl_t c;
    c.in_ready = (s == S_HDR_HI) || (s == S_HDR_LO) || (s == S_DATA);
    c.mem_we   = (s == S_WRITE);
    c.cpu_rst  = (s != S_DONE);
    c.done     = (s == S_DONE);
    c.err      = (s == S_ERR);
    return c;
  endfunction

endpackage

// File: rtl/ins_loader.sv
// Boot loader: packs a byte stream (16-bit word count N, then 4*N bytes, all
//   MSB first) into 32-bit words written to consecutive instruction-memory
//   word addresses; keeps the processor in reset until the image is in.
// Latency: write strobe one cycle after the 4th byte of a word is accepted;
//   done one cycle after the last write (or after the header when N=0).
// Backpressure: in_ready is low in IDLE, WRITE, DONE and ERR; gaps in
//   in_valid simply stall the FSM. Peak rate is 4 bytes per 5 cycles.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_data/valid/ready    byte stream, valid/ready handshake
//   start                  pulse: reload from DONE or ERR
//   mem_we/addr/wdata      instruction-memory write port (byte address)
//   cpu_rst                processor reset, low only once the image is done
//   done, err              image complete / header count too large
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        start,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam longint unsigned MAX_WORDS = 64'd1 << ADDR_W;

  state_t              state;
  ctl_t                ctl;
  logic [HDR_BITS-1:0] count;
  logic [ADDR_W:0]     word_idx;   // one extra bit so N == MAX_WORDS fits
  logic [1:0]          byte_cnt;
  logic [23:0]         shreg;      // first three bytes of the current word

  logic                accept;
  logic [HDR_BITS-1:0] hdr_n;
  logic                last_word;
  logic [31:0]         word_addr;

  assign in_ready = ctl.in_ready;
  assign mem_we   = ctl.mem_we;
  assign cpu_rst  = ctl.cpu_rst;
  assign done     = ctl.done;
  assign err      = ctl.err;

  assign accept = in_valid && ctl.in_ready;

  // Full count as it will be once the low header byte lands this cycle.
  assign hdr_n = {count[HDR_BITS-1:8], in_data};

  // The word being written is the last one when word_idx+1 reaches N.
  assign last_word = (({{(31 - ADDR_W){1'b0}}, word_idx} + 32'd1) ==
                      {{(32 - HDR_BITS){1'b0}}, count});

  // word_idx < N <= MAX_WORDS, so its top bit is never set while writing.
  assign word_addr = {{(30 - ADDR_W){1'b0}}, word_idx[ADDR_W-1:0], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ctl       <= ctl_for(S_IDLE);
      count     <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_HDR_HI;
          ctl   <= ctl_for(S_HDR_HI);
        end

        S_HDR_HI: begin
          if (accept) begin
            count[HDR_BITS-1:8] <= in_data;
            state               <= S_HDR_LO;
            ctl                 <= ctl_for(S_HDR_LO);
          end
        end

        S_HDR_LO: begin
          if (accept) begin
            count[7:0] <= in_data;
            if (hdr_n == '0) begin
              state <= S_DONE;
              ctl   <= ctl_for(S_DONE);
            end else if ({48'd0, hdr_n} > MAX_WORDS) begin
              state <= S_ERR;
              ctl   <= ctl_for(S_ERR);
            end else begin
              word_idx <= '0;
              byte_cnt <= '0;
              state    <= S_DATA;
              ctl      <= ctl_for(S_DATA);
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            shreg    <= {shreg[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
              // Present the finished word during the WRITE cycle.
              mem_addr  <= word_addr;
              mem_wdata <= {shreg, in_data};
              state     <= S_WRITE;
              ctl       <= ctl_for(S_WRITE);
            end
          end
        end

        S_WRITE: begin
          word_idx <= word_idx + 1'b1;
          byte_cnt <= '0;
          if (last_word) begin
            state <= S_DONE;
            ctl   <= ctl_for(S_DONE);
          end else begin
            state <= S_DATA;
            ctl   <= ctl_for(S_DATA);
          end
        end

        S_DONE, S_ERR: begin
          // Restart raises cpu_rst and drops done/err on this same edge.
          if (start) begin
            state <= S_HDR_HI;
            ctl   <= ctl_for(S_HDR_HI);
          end
        end

        default: begin
          state <= S_IDLE;
          ctl   <= ctl_for(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: a scoreboard queue of expected memory
// writes is filled from each stream as it is driven and drained by a monitor
// on the falling edge.
module tb_ins_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int errs   = 0;
  int checks = 0;

  logic [63:0] exp_q[$];   // {addr, data}
  int          wcount = 0;
  int          ncyc = 0;
  int          last_acc = -10;
  int          last_we = -10;
  logic        acc_flag = 1'b0;
  logic        prev_done = 1'b0;

  ins_loader #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Falling-edge monitor: scoreboard drain, write latency, done timing,
  // and the level relations between cpu_rst, done, err and in_ready.
  always @(negedge clk) begin
    logic [63:0] e;
    ncyc++;
    if (mem_we) begin
      chk("wr_latency", 32'(last_acc), 32'(ncyc - 1));
      if (exp_q.size() == 0) begin
        chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_wdata, e[31:0]);
      end
      wcount++;
      last_we = ncyc;
    end
    if (done && !prev_done)
      chk("done_timing", 32'((last_we == ncyc - 1) || (last_acc == ncyc - 1)), 32'd1);
    prev_done = done;
    chk("cpu_rst_vs_done", {31'd0, cpu_rst}, {31'd0, !done});
    if (done || err) chk("rdy_when_idle", {31'd0, in_ready}, 32'd0);
    acc_flag = in_valid && in_ready && !rst;
    if (acc_flag) last_acc = ncyc;
  end

  // Called at posedge+#1; returns at posedge+#1 of the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      if (acc_flag) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Pushes the writes the stream should produce, then drives it.
  task automatic send_stream(input bq_t b, input int gap);
    int n;
    n = {b[0], b[1]};
    if (n > 0 && n <= 256)
      for (int i = 0; i < n; i++)
        exp_q.push_back({32'(4 * i), b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]});
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i]);
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_flag(input bit want_err, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((want_err ? err : done) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
    chk("rst_mem_addr", mem_addr,          32'd0);
    chk("rst_mem_wdata", mem_wdata,        32'd0);
    chk("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_err",      {31'd0, err},      32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rdy_after_1st_edge", {31'd0, in_ready}, 32'd1);

    // start outside DONE/ERR is ignored.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_ignored_rdy", {31'd0, in_ready}, 32'd1);
    chk("start_ignored_cpu", {31'd0, cpu_rst},  32'd1);

    // Two words, in_valid held high.
    send_stream('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04}, 0);
    wait_flag(1'b0, "n2_done");
    chk("n2_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // Bytes offered in DONE are not taken.
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("done_holds", {31'd0, done}, 32'd1);

    // Empty image.
    pulse_start();
    chk("restart_done_low", {31'd0, done}, 32'd0);
    send_stream('{8'h00, 8'h00}, 0);
    wait_flag(1'b0, "n0_done");
    chk("n0_no_write", 32'(wcount), 32'd2);

    // Oversized count: 257 > 256 words.
    pulse_start();
    send_stream('{8'h01, 8'h01}, 0);
    wait_flag(1'b1, "n257_err");
    chk("err_in_ready", {31'd0, in_ready}, 32'd0);
    chk("err_cpu_rst",  {31'd0, cpu_rst},  32'd1);
    chk("err_done",     {31'd0, done},     32'd0);
    pulse_start();
    chk("err_cleared",  {31'd0, err},      32'd0);
    chk("err_restart_rdy", {31'd0, in_ready}, 32'd1);

    // Single word with gaps between bytes.
    send_stream('{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE}, 1);
    wait_flag(1'b0, "gap_done");

    // Reset in the middle of a word.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_mem_we",   {31'd0, mem_we},   32'd0);
    chk("midrst_mem_addr", mem_addr,          32'd0);
    chk("midrst_wdata",    mem_wdata,         32'd0);
    chk("midrst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
    chk("midrst_done",     {31'd0, done},     32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_stream('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0);
    wait_flag(1'b0, "postrst_done");

    // Reload after DONE.
    pulse_start();
    chk("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    send_stream('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
    wait_flag(1'b0, "reload_done");

    repeat (3) @(negedge clk);
    chk("sb_empty",     32'(exp_q.size()), 32'd0);
    chk("total_writes", 32'(wcount),       32'd5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ins_loader.md
# ins_loader

Boot-time program loader for the pipelined processor: the write side of instruction memory, which the processor only ever reads. Accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit big-endian instruction words and writes them to consecutive word addresses. Holds the processor in reset until the image is complete. Sits between an external byte source (UART receiver, testbench) and the instruction memory write port, alongside `Procesador`.

## Interface
- `ADDR_W`, 8: word-address width; capacity `MAX_WORDS` = 2^ADDR_W.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `start`  in  1  single-cycle pulse; restarts loading from DONE or ERR.
- `mem_we`  out  1  one-cycle instruction-memory write strobe.
- `mem_addr`  out  32  byte address, always a multiple of 4: {zeros, word_idx, 2'b00}.
- `mem_wdata`  out  32  instruction word.
- `cpu_rst`  out  1  holds the processor in reset while high.
- `done`  out  1  image fully written; level signal.
- `err`  out  1  header word count exceeds MAX_WORDS; level signal.

## Operation
- Stream format: 16-bit word count N, high byte first, then 4·N bytes, each word MSB first.
- A byte transfers on a rising edge with `in_valid && in_ready`.
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR.
- IDLE: `in_ready`=0. Goes to HDR_HI unconditionally on the next edge.
- HDR_HI: captures count[15:8].
- HDR_LO: captures count[7:0], then branches on N:
  - N=0 → DONE.
  - N>MAX_WORDS → ERR.
  - otherwise → DATA, with word_idx=0 and byte_cnt=0.
- DATA: shifts each byte into a 32-bit register (shift left 8). The 4th byte goes to WRITE.
- WRITE: `mem_we`=1 for exactly one cycle with `mem_addr`={word_idx,2'b00} and `mem_wdata`=the packed word. `in_ready`=0. Increments word_idx. Next state is DONE if word_idx+1==N, else DATA.
- DONE: `done`=1, `cpu_rst`=0, `in_ready`=0. Bytes offered in this state are not accepted.
- ERR: `err`=1, `cpu_rst`=1, `in_ready`=0, no writes.
- `start` in DONE or ERR → HDR_HI: clears `done`/`err` and raises `cpu_rst` on the same edge. `start` in any other state is ignored.
- `in_ready` = 1 exactly in HDR_HI, HDR_LO, DATA.
- `cpu_rst` = 1 in every state except DONE.
- Counters: word_idx is ADDR_W+1 bits and cannot wrap because N≤MAX_WORDS. byte_cnt is 2 bits. N is compared at 16 bits.

## Timing
- Reset values, asserted asynchronously: state IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rst`=1, `done`=0, `err`=0.
- First byte can be accepted on the 2nd rising edge after `rst` deasserts.
- Byte-to-write latency: the write strobe is the cycle immediately after the 4th byte's accept edge.
- Maximum throughput: 4 bytes per 5 cycles.
- Gaps in `in_valid` stall the FSM with no state change.
- `rst` mid-load abandons the partial word and all counters: no `mem_we`, back to IDLE, `cpu_rst` stays high. Words already written are not retracted.
- `done` rises the cycle after the last WRITE cycle, or the cycle after the HDR_LO accept when N=0.
- All outputs are driven from registers or a pure state decode; there is no combinational path from `in_valid` to any output.

## Structure
- Package `ins_loader_pkg`:
  - state enum;
  - HDR_BYTES=2, BYTES_PER_WORD=4.
- Byte packing is a few lines of logic, so there is no sub-module; a single module.
- Top level instantiates `ins_loader` next to `Procesador`; `cpu_rst` gates the processor's PC/buffers once they gain a reset input.

## Test plan
- Stream 00 02 | 20 08 00 05 | AC 08 00 04, `in_valid` held high → writes 0x20080005 @0x0 and 0xAC080004 @0x4, one cycle each. `done`=1 and `cpu_rst`=0 the cycle after the 2nd write.
- Stream 00 00 → no `mem_we`; `done`=1 the cycle after byte 2 is accepted.
- Stream 01 01 with ADDR_W=8 (N=257) → `err`=1, `in_ready`=0, `cpu_rst`=1, no writes. `start` pulse → back to HDR_HI with `err`=0.
- N=1 with `in_valid` toggling every other cycle → same single write (addr 0), issued 1 cycle after the 4th accepted byte; no duplicate accepts.
- Assert `rst` after 2 data bytes of N=1 → outputs at reset values immediately. A following full stream 00 01 DE AD BE EF writes 0xDEADBEEF @0x0.
- After DONE, pulse `start` and send 00 01 11 22 33 44 → `cpu_rst` high during the load; writes 0x11223344 @0x0; `done` reasserts.
